ctrl_fsm_param: RTL and testbench
=================================

CTRL_FSM_PARAM -- requirements
Module: ctrl_fsm_param

Interface
REQ-001 The block SHALL have parameter NUM_FIFOS, default 5, the number of monitored FIFOs (1..16).
REQ-002 The block SHALL have parameter TH_W, default 4, the threshold width per FIFO in bits (2..16).
REQ-003 The block SHALL have parameter IDLE_CYCLES, default 4, the number of consecutive all-empty cycles required for ACTIVE->IDLE (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port init, input, 1 bit: configuration request; forces or holds INIT.
REQ-007 The block SHALL have port th_high_in, input, NUM_FIFOS*TH_W bits: high thresholds; FIFO i at bits [i*TH_W +: TH_W].
REQ-008 The block SHALL have port th_low_in, input, NUM_FIFOS*TH_W bits: low thresholds, packed identically to th_high_in.
REQ-009 The block SHALL have port fifo_empties, input, NUM_FIFOS bits: bit i = 1 means FIFO i is empty.
REQ-010 The block SHALL have port fifo_errors, input, NUM_FIFOS bits: bit i = 1 means FIFO i has an overflow/underflow error this cycle.
REQ-011 The block SHALL have port err_clear, input, 1 bit: software acknowledge used to leave ERROR.
REQ-012 The block SHALL have port th_high_out, output, NUM_FIFOS*TH_W bits: latched high thresholds, registered.
REQ-013 The block SHALL have port th_low_out, output, NUM_FIFOS*TH_W bits: latched low thresholds, registered.
REQ-014 The block SHALL have ports idle_out, active_out and error_out, outputs, 1 bit each: one-hot state flags.
REQ-015 The block SHALL have port error_full, output, NUM_FIFOS bits: sticky per-FIFO error record.
REQ-016 The block SHALL have port cfg_err, output, 1 bit: some FIFO has low > high in the latched thresholds.
REQ-017 The block SHALL have port state_out, output, 3 bits: encoded current state.

Function
REQ-018 The FSM SHALL have states RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5-7 SHALL go to RESET on the next edge.
REQ-019 In RESET, the FSM SHALL move to INIT on the first clk edge with reset_L=1.
REQ-020 In INIT, th_high_out and th_low_out SHALL load th_high_in and th_low_in on every edge; cfg_err SHALL be computed from the loaded values, one cycle after load.
REQ-021 In states other than INIT, th_high_out and th_low_out SHALL hold their value.
REQ-022 INIT exit priority: any fifo_errors bit -> ERROR; else init=1 -> INIT; else cfg_err=1 -> INIT; else fifo_empties all ones -> IDLE; else -> ACTIVE.
REQ-023 IDLE exit priority: fifo_errors != 0 -> ERROR; else init=1 -> INIT; else fifo_empties != all ones -> ACTIVE; else stay.
REQ-024 In ACTIVE, an idle counter of width clog2(IDLE_CYCLES+1) SHALL increment, saturating at IDLE_CYCLES, on each all-empty cycle, and clear on any non-empty cycle.
REQ-025 ACTIVE exit priority: fifo_errors != 0 -> ERROR; else init=1 -> INIT; else (counter = IDLE_CYCLES-1 and all empty this cycle) -> IDLE; else stay.
REQ-026 The idle counter SHALL clear on every entry into ACTIVE.
REQ-027 error_full SHALL OR-accumulate fifo_errors on every edge in which the next state is ERROR or the current state is ERROR.
REQ-028 In ERROR, err_clear=1 with fifo_errors=0 SHALL move to INIT and zero error_full; err_clear=1 while fifo_errors != 0 SHALL be ignored.
REQ-029 Error has highest priority: fifo_errors and init asserted in the same cycle SHALL select ERROR.
REQ-030 idle_out, active_out, error_out and state_out SHALL decode directly from the state register, with no input-to-output combinational path.

Reset
REQ-031 While reset_L=0, the block SHALL force state RESET, zero all outputs, thresholds, error_full, cfg_err and the idle counter, regardless of clk.
REQ-032 Asserting reset mid-operation in any state SHALL take effect immediately, with no pending transition completing.

Verification
REQ-033 Bench SHALL check: reset release, init=0, all empty, th_high_in=0xFFFFF, th_low_in=0x11111 -> RESET, INIT, INIT (cfg_err=0 computed), IDLE; th_*_out equal the inputs.
REQ-034 Bench SHALL check: in IDLE, fifo_empties=5'b11110 -> ACTIVE next edge; then all empty for 4 cycles -> IDLE exactly after the 4th cycle; a non-empty cycle at the 3rd cycle restarts the count.
REQ-035 Bench SHALL check: in ACTIVE, fifo_errors=5'b00100, then 5'b01000 -> ERROR, error_out=1, error_full=5'b01100; err_clear with errors=0 -> INIT, error_full=0.
REQ-036 Bench SHALL check: in INIT, FIFO 2 has low=9, high=3 -> cfg_err=1 and INIT held; correcting to low=3 -> cfg_err=0, then IDLE.
REQ-037 Bench SHALL check: init and fifo_errors asserted together in IDLE -> ERROR; reset_L pulsed low asynchronously in ACTIVE -> all outputs 0 before the next clk edge.
REQ-038 Bench SHALL check: with NUM_FIFOS=8, TH_W=8, IDLE_CYCLES=1, rerunning REQ-033 to REQ-035 with scaled values -> same results.

Source files
------------

// File: rtl/ctrl_fsm_param.sv
// Threshold/error control FSM for a bank of monitored FIFOs.
// Latches per-FIFO thresholds in INIT, tracks idle/active activity and records FIFO errors.
module ctrl_fsm_param #(
    parameter int unsigned NUM_FIFOS   = 5,
    parameter int unsigned TH_W        = 4,
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      init,
    input  logic [NUM_FIFOS*TH_W-1:0] th_high_in,
    input  logic [NUM_FIFOS*TH_W-1:0] th_low_in,
    input  logic [NUM_FIFOS-1:0]      fifo_empties,
    input  logic [NUM_FIFOS-1:0]      fifo_errors,
    input  logic                      err_clear,
    output logic [NUM_FIFOS*TH_W-1:0] th_high_out,
    output logic [NUM_FIFOS*TH_W-1:0] th_low_out,
    output logic                      idle_out,
    output logic                      active_out,
    output logic                      error_out,
    output logic [NUM_FIFOS-1:0]      error_full,
    output logic                      cfg_err,
    output logic [2:0]                state_out
);

    localparam int unsigned TW    = NUM_FIFOS * TH_W;
    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          th_high_q, th_high_d;
    logic [TW-1:0]          th_low_q, th_low_d;
    logic [NUM_FIFOS-1:0]   err_full_q, err_full_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   loaded_q, loaded_d;
    logic                   cfg_err_calc;
    logic                   all_empty;
    logic                   any_err;

    assign all_empty = &fifo_empties;
    assign any_err   = |fifo_errors;

    always_comb begin
        cfg_err_calc = 1'b0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (th_low_in[i*TH_W +: TH_W] > th_high_in[i*TH_W +: TH_W]) begin
                cfg_err_calc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // loaded_q keeps INIT for one extra cycle so cfg_err reflects freshly latched thresholds
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (any_err)           state_d = StError;
                else if (init)         state_d = StInit;
                else if (!loaded_q)    state_d = StInit;
                else if (cfg_err_q)    state_d = StInit;
                else if (all_empty)    state_d = StIdle;
                else                   state_d = StActive;
            end
            StIdle: begin
                if (any_err)           state_d = StError;
                else if (init)         state_d = StInit;
                else if (!all_empty)   state_d = StActive;
            end
            StActive: begin
                if (any_err)                               state_d = StError;
                else if (init)                             state_d = StInit;
                else if (cnt_q == CNT_LAST && all_empty)   state_d = StIdle;
            end
            StError: begin
                if (err_clear && !any_err) state_d = StInit;
            end
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        th_high_d  = th_high_q;
        th_low_d   = th_low_q;
        cfg_err_d  = cfg_err_q;
        loaded_d   = (state_q == StInit);
        cnt_d      = '0;
        err_full_d = err_full_q;
        if (state_q == StInit) begin
            th_high_d = th_high_in;
            th_low_d  = th_low_in;
            cfg_err_d = cfg_err_calc;
        end
        if (state_q == StActive && all_empty) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (state_q == StError && state_d == StInit) begin
            err_full_d = '0;
        end else if (state_d == StError || state_q == StError) begin
            err_full_d = err_full_q | fifo_errors;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            th_high_q  <= '0;
            th_low_q   <= '0;
            cfg_err_q  <= 1'b0;
            loaded_q   <= 1'b0;
            cnt_q      <= '0;
            err_full_q <= '0;
        end else begin
            th_high_q  <= th_high_d;
            th_low_q   <= th_low_d;
            cfg_err_q  <= cfg_err_d;
            loaded_q   <= loaded_d;
            cnt_q      <= cnt_d;
            err_full_q <= err_full_d;
        end
    end

    always_comb begin
        idle_out    = (state_q == StIdle);
        active_out  = (state_q == StActive);
        error_out   = (state_q == StError);
        state_out   = state_q;
        th_high_out = th_high_q;
        th_low_out  = th_low_q;
        error_full  = err_full_q;
        cfg_err     = cfg_err_q;
    end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Directed bench for ctrl_fsm_param: default instance plus an 8x8, IDLE_CYCLES=1 instance.
module tb_ctrl_fsm_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NUM_FIFOS=5, TH_W=4, IDLE_CYCLES=4
    logic        rst_a, init_a, clr_a;
    logic [19:0] thh_a, thl_a, thh_out_a, thl_out_a;
    logic [4:0]  emp_a, err_a, efull_a;
    logic        idle_a, act_a, errst_a, cfg_a;
    logic [2:0]  st_a;

    // Instance B: NUM_FIFOS=8, TH_W=8, IDLE_CYCLES=1
    logic        rst_b, init_b, clr_b;
    logic [63:0] thh_b, thl_b, thh_out_b, thl_out_b;
    logic [7:0]  emp_b, err_b, efull_b;
    logic        idle_b, act_b, errst_b, cfg_b;
    logic [2:0]  st_b;

    ctrl_fsm_param #(.NUM_FIFOS(5), .TH_W(4), .IDLE_CYCLES(4)) u_dut_a (
        .clk(clk), .reset_L(rst_a), .init(init_a),
        .th_high_in(thh_a), .th_low_in(thl_a),
        .fifo_empties(emp_a), .fifo_errors(err_a), .err_clear(clr_a),
        .th_high_out(thh_out_a), .th_low_out(thl_out_a),
        .idle_out(idle_a), .active_out(act_a), .error_out(errst_a),
        .error_full(efull_a), .cfg_err(cfg_a), .state_out(st_a)
    );

    ctrl_fsm_param #(.NUM_FIFOS(8), .TH_W(8), .IDLE_CYCLES(1)) u_dut_b (
        .clk(clk), .reset_L(rst_b), .init(init_b),
        .th_high_in(thh_b), .th_low_in(thl_b),
        .fifo_empties(emp_b), .fifo_errors(err_b), .err_clear(clr_b),
        .th_high_out(thh_out_b), .th_low_out(thl_out_b),
        .idle_out(idle_b), .active_out(act_b), .error_out(errst_b),
        .error_full(efull_b), .cfg_err(cfg_b), .state_out(st_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // state code and {idle,active,error} flags together
    task automatic chk_a(input string tag, input logic [2:0] st);
        logic [2:0] fl;
        fl = {st == 3'd2, st == 3'd3, st == 3'd4};
        chk({tag, "_st"}, 64'(st_a), 64'(st));
        chk({tag, "_fl"}, 64'({idle_a, act_a, errst_a}), 64'(fl));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] st);
        logic [2:0] fl;
        fl = {st == 3'd2, st == 3'd3, st == 3'd4};
        chk({tag, "_st"}, 64'(st_b), 64'(st));
        chk({tag, "_fl"}, 64'({idle_b, act_b, errst_b}), 64'(fl));
    endtask

    initial begin
        rst_a = 1'b0; init_a = 1'b0; clr_a = 1'b0;
        thh_a = 20'hFFFFF; thl_a = 20'h11111; emp_a = 5'h1F; err_a = 5'h00;
        rst_b = 1'b0; init_b = 1'b0; clr_b = 1'b0;
        thh_b = 64'hFFFF_FFFF_FFFF_FFFF; thl_b = 64'h1111_1111_1111_1111;
        emp_b = 8'hFF; err_b = 8'h00;

        // Reset state, asynchronous (before any clock edge)
        #2;
        chk_a("a_rst", 3'd0);
        chk("a_rst_thh", 64'(thh_out_a), 64'h0);
        chk("a_rst_efull", 64'(efull_a), 64'h0);
        chk("a_rst_cfg", 64'(cfg_a), 64'h0);
        step(); step();
        rst_a = 1'b1;
        chk_a("a_rel", 3'd0);

        // RESET -> INIT -> INIT -> IDLE
        step(); chk_a("a_init1", 3'd1);
        step(); chk_a("a_init2", 3'd1);
        chk("a_thh", 64'(thh_out_a), 64'hFFFFF);
        chk("a_thl", 64'(thl_out_a), 64'h11111);
        chk("a_cfg0", 64'(cfg_a), 64'h0);
        step(); chk_a("a_idle", 3'd2);

        // IDLE -> ACTIVE, then exactly 4 all-empty cycles back to IDLE
        emp_a = 5'b11110;
        step(); chk_a("a_act", 3'd3);
        emp_a = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            step(); chk_a("a_cnt", 3'd3);
        end
        step(); chk_a("a_idle4", 3'd2);

        // Non-empty on the 3rd cycle restarts the count
        emp_a = 5'b11110;
        step(); chk_a("a_act2", 3'd3);
        emp_a = 5'h1F;
        step(); step();
        emp_a = 5'b11110;
        step(); chk_a("a_restart", 3'd3);
        emp_a = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            step(); chk_a("a_recnt", 3'd3);
        end
        step(); chk_a("a_idle_r", 3'd2);

        // ACTIVE -> ERROR, sticky accumulation, clear
        emp_a = 5'b11110;
        step(); chk_a("a_act3", 3'd3);
        err_a = 5'b00100;
        step(); chk_a("a_err", 3'd4);
        chk("a_efull1", 64'(efull_a), 64'h04);
        err_a = 5'b01000;
        step(); chk("a_efull2", 64'(efull_a), 64'h0C);
        clr_a = 1'b1;
        step(); chk_a("a_clr_ign", 3'd4);
        err_a = 5'b00000;
        step(); chk_a("a_clr", 3'd1);
        chk("a_efull0", 64'(efull_a), 64'h0);
        clr_a = 1'b0;

        // Bad config on FIFO 2 (low=9 > high=3) holds INIT
        thh_a = 20'hFF3FF; thl_a = 20'h11911; emp_a = 5'h1F;
        step(); chk("a_cfg1", 64'(cfg_a), 64'h1); chk_a("a_cfg_hold1", 3'd1);
        step(); chk("a_cfg1b", 64'(cfg_a), 64'h1); chk_a("a_cfg_hold2", 3'd1);
        thl_a = 20'h11311;
        step(); chk("a_cfg_fix", 64'(cfg_a), 64'h0); chk_a("a_cfg_hold3", 3'd1);
        step(); chk_a("a_cfg_idle", 3'd2);

        // init and errors together in IDLE -> ERROR
        init_a = 1'b1; err_a = 5'b00001;
        step(); chk_a("a_prio", 3'd4);
        chk("a_prio_efull", 64'(efull_a), 64'h01);
        init_a = 1'b0; err_a = 5'h00; clr_a = 1'b1;
        step(); chk_a("a_prio_clr", 3'd1);
        clr_a = 1'b0;
        step(); step(); chk_a("a_back_idle", 3'd2);
        emp_a = 5'b11110;
        step(); chk_a("a_act4", 3'd3);

        // Asynchronous reset mid-ACTIVE
        #2 rst_a = 1'b0;
        #1;
        chk_a("a_arst", 3'd0);
        chk("a_arst_thh", 64'(thh_out_a), 64'h0);
        chk("a_arst_thl", 64'(thl_out_a), 64'h0);
        chk("a_arst_cfg", 64'(cfg_a), 64'h0);
        rst_a = 1'b1;

        // Instance B: same flow with scaled widths and IDLE_CYCLES=1
        step();
        chk_b("b_rst", 3'd0);
        rst_b = 1'b1;
        step(); chk_b("b_init1", 3'd1);
        step(); chk_b("b_init2", 3'd1);
        chk("b_thh", thh_out_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b_thl", thl_out_b, 64'h1111_1111_1111_1111);
        chk("b_cfg0", 64'(cfg_b), 64'h0);
        step(); chk_b("b_idle", 3'd2);
        emp_b = 8'hFE;
        step(); chk_b("b_act", 3'd3);
        emp_b = 8'hFF;
        step(); chk_b("b_idle1", 3'd2);
        emp_b = 8'hFE;
        step(); chk_b("b_act2", 3'd3);
        err_b = 8'h04;
        step(); chk_b("b_err", 3'd4);
        chk("b_efull1", 64'(efull_b), 64'h04);
        err_b = 8'h08;
        step(); chk("b_efull2", 64'(efull_b), 64'h0C);
        err_b = 8'h00; clr_b = 1'b1;
        step(); chk_b("b_clr", 3'd1);
        chk("b_efull0", 64'(efull_b), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
